rv32m_issue_queue: RTL and testbench

//  Buffers RV32M ops from decode, issues them one at a time to the iterative
//  mul/div unit (rv32m_muldiv), and registers each result with its rd tag for

---
 rtl/rv32m_issue_queue.sv | 137 +++++++++++++
 tb/tb_rv32m_issue_queue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32m_issue_queue.sv
// rtl/rv32m_issue_queue.sv - RV32M op queue feeding a non-pipelined mul/div unit with writeback register
module rv32m_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_op_sel,
  input  logic [31:0]              in_rs1,
  input  logic [31:0]              in_rs2,
  input  logic [TAG_W-1:0]         in_rd,
  output logic                     in_err,
  input  logic                     flush,
  output logic                     md_op_valid,
  output logic [4:0]               md_op_sel,
  output logic [31:0]              md_rs1,
  output logic [31:0]              md_rs2,
  input  logic                     md_busy,
  input  logic                     md_done,
  input  logic [31:0]              md_result,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [TAG_W-1:0]         wb_rd,
  output logic [31:0]              wb_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;
  state_t state;

  logic [4:0]       q_op  [DEPTH];
  logic [31:0]      q_rs1 [DEPTH];
  logic [31:0]      q_rs2 [DEPTH];
  logic [TAG_W-1:0] q_rd  [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  logic full;
  logic offer;
  logic push;
  logic load;

  // The head stays in the FIFO while in flight, so a full queue is never ready
  assign full     = (count == FULL_CNT);
  assign in_ready = !full && (state != DRAIN);
  assign offer    = in_valid && in_ready;
  assign push     = offer && in_op_sel[4] && !flush;
  assign load     = (state == WAIT) && md_done && !flush;

  // Operands come straight from the head; it only pops on md_done so they stay stable
  assign md_op_sel = q_op[rd_ptr];
  assign md_rs1    = q_rs1[rd_ptr];
  assign md_rs2    = q_rs2[rd_ptr];

  // FIFO payload storage, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (push) begin
      q_op[wr_ptr]  <= in_op_sel;
      q_rs1[wr_ptr] <= in_rs1;
      q_rs2[wr_ptr] <= in_rs2;
      q_rd[wr_ptr]  <= in_rd;
    end
  end

  // Pointers and occupancy; flush empties the queue outright
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (load) rd_ptr <= rd_ptr + PW'(1);
      case ({push, load})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue sequencing; the unit cannot be aborted, so a flush while busy waits out md_done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      md_op_valid <= 1'b0;
    end else begin
      md_op_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!flush && (count != '0) && !md_busy && (!wb_valid || wb_ready)) begin
            state       <= ISSUE;
            md_op_valid <= 1'b1;
          end
        end
        ISSUE: state <= flush ? DRAIN : WAIT;
        WAIT: begin
          if (md_done)    state <= IDLE;
          else if (flush) state <= DRAIN;
        end
        DRAIN: begin
          if (md_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Writeback register: loads on completion, holds until consumed, cleared by flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
    end else if (load) begin
      wb_valid <= 1'b1;
      wb_rd    <= q_rd[rd_ptr];
      wb_data  <= md_result;
    end else if (wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

  // One-cycle error pulse for an offered op outside the RV32M encoding
  always_ff @(posedge clk) begin
    if (!rst_n) in_err <= 1'b0;
    else        in_err <= offer && !in_op_sel[4];
  end

endmodule

// File: tb/tb_rv32m_issue_queue.sv
// tb/tb_rv32m_issue_queue.sv - randomized bench with queue-level reference model for rv32m_issue_queue
module tb_rv32m_issue_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, in_valid, in_ready, in_err, flush;
  logic              md_op_valid, md_busy, md_done, wb_valid, wb_ready;
  logic [4:0]        in_op_sel, md_op_sel;
  logic [31:0]       in_rs1, in_rs2, md_rs1, md_rs2, md_result, wb_data;
  logic [TAG_W-1:0]  in_rd, wb_rd;
  logic [2:0]        count;

  rv32m_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op_sel(in_op_sel), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_err(in_err), .flush(flush), .md_op_valid(md_op_valid),
    .md_op_sel(md_op_sel), .md_rs1(md_rs1), .md_rs2(md_rs2),
    .md_busy(md_busy), .md_done(md_done), .md_result(md_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .count(count)
  );

  typedef struct packed {
    logic [4:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] rd;
  } ent_t;

  // Reference model: queued ops, issue phase (0 idle, 1 issuing, 2 waiting, 3 draining)
  ent_t             mq[$];
  int               m_phase;
  logic             m_wbv, m_err;
  logic [TAG_W-1:0] m_wbrd;
  logic [31:0]      m_wbd;

  // Mul/div unit stand-in
  int          u_cnt;
  int          force_lat;
  logic [4:0]  u_op;
  logic [31:0] u_a, u_b;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    logic ovf;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    ref_result = 32'h0;
    case (op[2:0])
      3'd0: begin p = ua * ub; ref_result = p[31:0]; end
      3'd1: begin p = sa * sb; ref_result = p[63:32]; end
      3'd2: begin p = sa * $signed(ub); ref_result = p[63:32]; end
      3'd3: begin p = ua * ub; ref_result = p[63:32]; end
      3'd4: ref_result = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : $signed(a) / $signed(b);
      3'd5: ref_result = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: ref_result = (b == 0) ? a : ovf ? 32'h0 : $signed(a) % $signed(b);
      default: ref_result = (b == 0) ? a : a % b;
    endcase
  endfunction

  // One clock cycle: compare outputs to the model, advance the unit, drive inputs, advance the model
  task automatic step(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] rd, input logic fl, input logic wr, input logic rs);
    logic exp_ready, push, load, go;
    ent_t e;
    @(negedge clk);
    exp_ready = (mq.size() < DEPTH) && (m_phase != 3);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("md_op_valid", 32'(md_op_valid), 32'(m_phase == 1));
    chk("count", 32'(count), 32'(mq.size()));
    chk("in_err", 32'(in_err), 32'(m_err));
    chk("wb_valid", 32'(wb_valid), 32'(m_wbv));
    if (m_wbv) begin
      chk("wb_rd", 32'(wb_rd), 32'(m_wbrd));
      chk("wb_data", wb_data, m_wbd);
    end
    if ((m_phase == 1 || m_phase == 2) && mq.size() > 0) begin
      chk("md_op_sel", 32'(md_op_sel), 32'(mq[0].op));
      chk("md_rs1", md_rs1, mq[0].a);
      chk("md_rs2", md_rs2, mq[0].b);
    end

    md_done = 1'b0;
    if (u_cnt > 0) begin
      u_cnt--;
      if (u_cnt == 0) begin
        md_done   = 1'b1;
        md_result = ref_result(u_op, u_a, u_b);
      end
    end
    if (md_op_valid) begin
      u_op = md_op_sel;
      u_a  = md_rs1;
      u_b  = md_rs2;
      if (force_lat > 0) u_cnt = force_lat;
      else if (u_op[2] && u_b == 0) u_cnt = 1;
      else u_cnt = int'($urandom_range(1, 5));
    end
    md_busy = (u_cnt > 0);

    in_valid = v; in_op_sel = op; in_rs1 = a; in_rs2 = b; in_rd = rd;
    flush = fl; wb_ready = wr; rst_n = rs;

    if (!rs) begin
      mq.delete();
      m_phase = 0; m_wbv = 1'b0; m_wbrd = '0; m_wbd = '0; m_err = 1'b0;
      u_cnt = 0;
    end else begin
      push  = v && exp_ready && op[4] && !fl;
      m_err = v && exp_ready && !op[4];
      load  = (m_phase == 2) && md_done && !fl;
      go    = (m_phase == 0) && !fl && (mq.size() != 0) && !md_busy && (!m_wbv || wr);
      if (fl) m_wbv = 1'b0;
      else if (load) begin
        m_wbv  = 1'b1;
        m_wbrd = mq[0].rd;
        m_wbd  = ref_result(mq[0].op, mq[0].a, mq[0].b);
      end else if (wr) m_wbv = 1'b0;
      case (m_phase)
        0: if (go) m_phase = 1;
        1: m_phase = fl ? 3 : 2;
        2: if (md_done) m_phase = 0; else if (fl) m_phase = 3;
        default: if (md_done) m_phase = 0;
      endcase
      if (fl) mq.delete();
      else begin
        if (load) void'(mq.pop_front());
        if (push) begin
          e.op = op; e.a = a; e.b = b; e.rd = rd;
          mq.push_back(e);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'b10000, 32'h0, 32'h0, '0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic wait_wb(input string nm, input logic [TAG_W-1:0] rd, input logic [31:0] data);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 5'b10000, 32'h0, 32'h0, '0, 1'b0, 1'b1, 1'b1);
      if (wb_valid === 1'b1) begin
        chk({nm, " rd"}, 32'(wb_rd), 32'(rd));
        chk({nm, " data"}, wb_data, data);
        return;
      end
    end
    chk({nm, " timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic [4:0] rop;
    logic [31:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; in_op_sel = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    flush = 1'b0; wb_ready = 1'b1; md_busy = 1'b0; md_done = 1'b0; md_result = '0;
    u_cnt = 0; force_lat = 0; u_op = '0; u_a = '0; u_b = '0;
    mq.delete(); m_phase = 0; m_wbv = 1'b0; m_err = 1'b0; m_wbrd = '0; m_wbd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset count", 32'(count), 32'd0);
    chk("reset md_op_valid", 32'(md_op_valid), 32'd0);
    chk("reset wb_valid", 32'(wb_valid), 32'd0);
    chk("reset wb_data", wb_data, 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);

    // T1: MUL 7*6 with two-cycle issue latency
    step(1'b1, 5'b10000, 32'd7, 32'd6, 5'd3, 1'b0, 1'b1, 1'b1);
    idle(1);
    chk("t1 no early issue", 32'(md_op_valid), 32'd0);
    idle(1);
    chk("t1 issue strobe", 32'(md_op_valid), 32'd1);
    wait_wb("t1", 5'd3, 32'd42);
    idle(1);
    chk("t1 count", 32'(count), 32'd0);

    // T2: divide-by-zero fast paths, in order
    step(1'b1, 5'b10101, 32'd100, 32'd0, 5'd1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 5'b10111, 32'd100, 32'd0, 5'd2, 1'b0, 1'b1, 1'b1);
    wait_wb("t2 divu", 5'd1, 32'hFFFF_FFFF);
    wait_wb("t2 remu", 5'd2, 32'd100);
    idle(3);

    // T3: fill to DEPTH with writeback stalled
    force_lat = 8;
    for (int i = 0; i < 5; i++)
      step(1'b1, 5'b10000, 32'(i + 1), 32'(i + 2), 5'(10 + i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'b10000, 32'd5, 32'd6, 5'd14, 1'b0, 1'b0, 1'b1);
    chk("t3 full count", 32'(count), 32'd4);
    chk("t3 full not ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 20; i++)
      step(1'b1, 5'b10000, 32'd5, 32'd6, 5'd14, 1'b0, 1'b0, 1'b1);
    chk("t3 held rd", 32'(wb_rd), 32'd10);
    chk("t3 held data", wb_data, 32'd2);
    chk("t3 count", 32'(count), 32'd4);
    force_lat = 0;
    idle(60);

    // T4: flush while a DIV is in flight
    force_lat = 6;
    step(1'b1, 5'b10100, 32'hFFFF_FFF8, 32'd3, 5'd4, 1'b0, 1'b1, 1'b1);
    idle(3);
    step(1'b0, 5'b10000, 32'h0, 32'h0, '0, 1'b1, 1'b1, 1'b1);
    idle(1);
    chk("t4 drain not ready", 32'(in_ready), 32'd0);
    chk("t4 drain count", 32'(count), 32'd0);
    idle(10);
    chk("t4 result discarded", 32'(wb_valid), 32'd0);
    force_lat = 0;
    step(1'b1, 5'b10011, 32'hFFFF_FFFF, 32'd2, 5'd6, 1'b0, 1'b1, 1'b1);
    wait_wb("t4 mulhu", 5'd6, 32'd1);
    idle(3);

    // T5: illegal op code, then flush racing a push
    step(1'b1, 5'b00101, 32'd1, 32'd1, 5'd9, 1'b0, 1'b1, 1'b1);
    idle(1);
    chk("t5 in_err", 32'(in_err), 32'd1);
    chk("t5 count", 32'(count), 32'd0);
    step(1'b1, 5'b10000, 32'd2, 32'd3, 5'd9, 1'b1, 1'b1, 1'b1);
    idle(1);
    chk("t5 flush wins", 32'(count), 32'd0);
    idle(2);

    // T6: reset in the middle of a MUL
    force_lat = 6;
    step(1'b1, 5'b10000, 32'd3, 32'd5, 5'd7, 1'b0, 1'b1, 1'b1);
    idle(3);
    step(1'b0, 5'b10000, 32'h0, 32'h0, '0, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("t6 md_op_valid", 32'(md_op_valid), 32'd0);
    chk("t6 wb_valid", 32'(wb_valid), 32'd0);
    chk("t6 wb_rd", 32'(wb_rd), 32'd0);
    chk("t6 count", 32'(count), 32'd0);
    force_lat = 0;
    step(1'b1, 5'b10000, 32'd9, 32'd9, 5'd8, 1'b0, 1'b1, 1'b1);
    wait_wb("t6 mul", 5'd8, 32'd81);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? {1'b0, 4'($urandom)} : {2'b10, 3'($urandom)};
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 15) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      step(1'($urandom), rop, ra, rb, TAG_W'($urandom),
           1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 499) != 0));
    end
    idle(40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
